// File: rtl/panda_pkg.sv
// Shared decode types for the instruction decode stage: ALU operation
// encoding, the control bundle handed to EX, immediate format tags and
// RV32I major opcodes.
package panda_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    // MSB first: use_imm is bit 7, illegal is bit 0.
    typedef struct packed {
        logic use_imm;
        logic use_pc;
        logic reg_we;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    // Instruction format; also tells which register fields are meaningful.
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Arithmetic op selection shared by OP and OP-IMM. Bit 30 picks SRA
    // over SRL for both, but SUB over ADD only for register-register ops
    // (ADDI has no subtract form; bit 30 there is just immediate).
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt,
                                                input logic       is_reg);
        case (funct3)
            3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode_imm_gen.sv
// Immediate generator: classifies the instruction word by format and
// extracts the sign-extended immediate. Purely combinational.
module imm_gen
    import panda_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic [31:0]        instr,
    output fmt_t               fmt,
    output logic [BITSIZE-1:0] imm
);

    logic [31:0] imm_word;

    // Format from the major opcode.
    always_comb begin
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_STORE:                     fmt = FMT_S;
            OPC_OP:                        fmt = FMT_R;
            default:                       fmt = FMT_NONE;
        endcase
    end

    // Immediate bit scatter per format; bit 31 is always the sign.
    always_comb begin
        case (fmt)
            FMT_I:   imm_word = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm_word = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm_word = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm_word = {instr[31:12], 12'b0};
            FMT_J:   imm_word = {{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
            default: imm_word = 32'b0;
        endcase
    end

    assign imm = imm_word;

endmodule

// File: rtl/instr_decode.sv
// Instruction decode stage: takes one instruction from IF, decodes it in a
// dedicated cycle and holds the bundle until EX takes it.
// Optional feature macro: PANDA_ID_ILLEGAL_TRAP_EN (flag unknown encodings
// as illegal instead of turning them into a NOP).
module instr_decode
    import panda_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               resetn_i,
    output logic               ID_IF_get_o,
    input  logic               IF_ID_give_i,
    input  logic [31:0]        IF_ID_instr_i,
    input  logic               EX_ID_get_i,
    output logic               ID_EX_give_o,
    output logic [4:0]         ID_EX_rs1_o,
    output logic [4:0]         ID_EX_rs2_o,
    output logic [4:0]         ID_EX_rd_o,
    output logic [BITSIZE-1:0] ID_EX_imm_o,
    output alu_op_t            ID_EX_aluop_o,
    output ctrl_t              ID_EX_ctrl_o,
    output logic [2:0]         ID_EX_funct3_o
);

    localparam logic [1:0] ST_REQUEST = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_PROVIDE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [31:0]        instr_q;
    fmt_t               fmt;
    logic [BITSIZE-1:0] imm_word;
    logic               legal;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic [4:0]         dec_rd;
    logic [BITSIZE-1:0] dec_imm;
    alu_op_t            dec_aluop;
    ctrl_t              dec_ctrl;

    imm_gen #(.BITSIZE(BITSIZE)) u_imm_gen (
        .instr (instr_q),
        .fmt   (fmt),
        .imm   (imm_word)
    );

    // Handshakes are gated by reset so nothing is requested or given in a reset cycle.
    assign ID_IF_get_o  = resetn_i && (state == ST_REQUEST);
    assign ID_EX_give_o = resetn_i && (state == ST_PROVIDE) && EX_ID_get_i;

    // Next state: accept from IF, one decode cycle, then wait for EX.
    always_comb begin
        case (state)
            ST_REQUEST: state_next = IF_ID_give_i ? ST_DECODE : ST_REQUEST;
            ST_DECODE:  state_next = ST_PROVIDE;
            ST_PROVIDE: state_next = EX_ID_get_i ? ST_REQUEST : ST_PROVIDE;
            default:    state_next = ST_REQUEST;
        endcase
    end

    // Field decode of the held word; unknown encodings collapse to one bundle.
    always_comb begin
        legal     = 1'b1;
        dec_rs1   = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B)
                    ? instr_q[19:15] : 5'd0;
        dec_rs2   = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? instr_q[24:20] : 5'd0;
        dec_rd    = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
                    ? instr_q[11:7] : 5'd0;
        dec_imm   = imm_word;
        dec_aluop = ALU_ADD;
        dec_ctrl  = '0;
        case (instr_q[6:0])
            OPC_LUI: begin
                dec_aluop = ALU_PASS_B;
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.use_pc  = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.use_pc  = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
                dec_ctrl.jump    = 1'b1;
            end
            OPC_JALR: begin
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
                dec_ctrl.jump    = 1'b1;
            end
            OPC_BRANCH: begin
                // Comparison itself is resolved in EX from funct3.
                dec_aluop = ALU_SUB;
                dec_ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
                dec_ctrl.mem_rd  = 1'b1;
            end
            OPC_STORE: begin
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.mem_wr  = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_aluop = alu_from_funct3(instr_q[14:12], instr_q[30], 1'b0);
                dec_ctrl.use_imm = 1'b1;
                dec_ctrl.reg_we  = 1'b1;
            end
            OPC_OP: begin
                dec_aluop = alu_from_funct3(instr_q[14:12], instr_q[30], 1'b1);
                dec_ctrl.reg_we = 1'b1;
                if (instr_q[31:25] != 7'b0000000 && instr_q[31:25] != 7'b0100000) begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_rs1   = 5'd0;
            dec_rs2   = 5'd0;
            dec_rd    = 5'd0;
            dec_imm   = '0;
            dec_aluop = ALU_ADD;
            dec_ctrl  = '0;
`ifdef PANDA_ID_ILLEGAL_TRAP_EN
            dec_ctrl.illegal = 1'b1;
`else
            // ADDI x0,x0,0
            dec_ctrl.use_imm = 1'b1;
`endif
        end
    end

    // State, instruction capture and the decoded bundle held for EX.
    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            state          <= ST_REQUEST;
            instr_q        <= 32'b0;
            ID_EX_rs1_o    <= 5'd0;
            ID_EX_rs2_o    <= 5'd0;
            ID_EX_rd_o     <= 5'd0;
            ID_EX_imm_o    <= '0;
            ID_EX_aluop_o  <= ALU_ADD;
            ID_EX_ctrl_o   <= '0;
            ID_EX_funct3_o <= 3'd0;
        end else begin
            state <= state_next;
            if (state == ST_REQUEST && IF_ID_give_i) begin
                instr_q <= IF_ID_instr_i;
            end
            if (state == ST_DECODE) begin
                ID_EX_rs1_o    <= dec_rs1;
                ID_EX_rs2_o    <= dec_rs2;
                ID_EX_rd_o     <= dec_rd;
                ID_EX_imm_o    <= dec_imm;
                ID_EX_aluop_o  <= dec_aluop;
                ID_EX_ctrl_o   <= dec_ctrl;
                ID_EX_funct3_o <= instr_q[14:12];
            end
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Testbench for instr_decode: directed vector table, randomized instructions
// against a behavioural decode model, and a mid-operation reset sequence.
module tb_instr_decode;
    import panda_pkg::*;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic [7:0]  ctrl;
        logic [2:0]  f3;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        int          hold;
        bit          spur;
        bundle_t     exp;
    } vec_t;

    localparam logic [7:0] C_IMM = 8'h80, C_PC = 8'h40, C_WE = 8'h20, C_MR = 8'h10;
    localparam logic [7:0] C_MW = 8'h08, C_BR = 8'h04, C_JP = 8'h02, C_IL = 8'h01;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        get_o;
    logic        give_i = 1'b0;
    logic [31:0] instr_i = 32'b0;
    logic        ex_get = 1'b0;
    logic        give_o;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [7:0]  ctrl;
    logic [2:0]  f3;
    bundle_t     act;

    int checks = 0;
    int errors = 0;

    instr_decode #(.BITSIZE(32)) dut (
        .clk            (clk),
        .resetn_i       (resetn),
        .ID_IF_get_o    (get_o),
        .IF_ID_give_i   (give_i),
        .IF_ID_instr_i  (instr_i),
        .EX_ID_get_i    (ex_get),
        .ID_EX_give_o   (give_o),
        .ID_EX_rs1_o    (rs1),
        .ID_EX_rs2_o    (rs2),
        .ID_EX_rd_o     (rd),
        .ID_EX_imm_o    (imm),
        .ID_EX_aluop_o  (aluop),
        .ID_EX_ctrl_o   (ctrl),
        .ID_EX_funct3_o (f3)
    );

    always #5 clk = ~clk;

    assign act = {rs1, rs2, rd, imm, aluop, ctrl, f3};

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic bundle_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                   input logic [31:0] im, input logic [3:0] op,
                                   input logic [7:0] c, input logic [2:0] fn3);
        bundle_t b;
        b.rs1 = r1; b.rs2 = r2; b.rd = d; b.imm = im; b.aluop = op; b.ctrl = c; b.f3 = fn3;
        return b;
    endfunction

    // Reference decode, built from the ISA field definitions.
    function automatic bundle_t model(input logic [31:0] w);
        bundle_t     b;
        bit          ok;
        logic [31:0] sgn, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [3:0]  arith;
        logic [3:0]  tab [8];
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        sgn   = ($signed(w) >>> 31);
        i_imm = ($signed(w) >>> 20);
        s_imm = (i_imm & ~32'h1F) | ((w >> 7) & 32'h1F);
        b_imm = (sgn << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
              | (((w >> 8) & 32'hF) << 1);
        u_imm = w & 32'hFFFFF000;
        j_imm = (sgn << 20) | (w & 32'h000FF000) | (((w >> 20) & 32'h1) << 11)
              | (((w >> 21) & 32'h3FF) << 1);
        arith = tab[w[14:12]];
        if (w[14:12] == 3'd5 && w[30]) arith = ALU_SRA;
        ok = 1'b1;
        b = '0;
        b.f3 = w[14:12];
        case (w[6:0])
            7'b0110111: begin b.rd = w[11:7]; b.imm = u_imm; b.aluop = ALU_PASS_B; b.ctrl = C_IMM | C_WE; end
            7'b0010111: begin b.rd = w[11:7]; b.imm = u_imm; b.aluop = ALU_ADD; b.ctrl = C_IMM | C_PC | C_WE; end
            7'b1101111: begin b.rd = w[11:7]; b.imm = j_imm; b.aluop = ALU_ADD; b.ctrl = C_IMM | C_PC | C_WE | C_JP; end
            7'b1100111: begin b.rd = w[11:7]; b.rs1 = w[19:15]; b.imm = i_imm; b.aluop = ALU_ADD; b.ctrl = C_IMM | C_WE | C_JP; end
            7'b1100011: begin b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.imm = b_imm; b.aluop = ALU_SUB; b.ctrl = C_BR; end
            7'b0000011: begin b.rd = w[11:7]; b.rs1 = w[19:15]; b.imm = i_imm; b.aluop = ALU_ADD; b.ctrl = C_IMM | C_WE | C_MR; end
            7'b0100011: begin b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.imm = s_imm; b.aluop = ALU_ADD; b.ctrl = C_IMM | C_MW; end
            7'b0010011: begin b.rd = w[11:7]; b.rs1 = w[19:15]; b.imm = i_imm; b.aluop = arith; b.ctrl = C_IMM | C_WE; end
            7'b0110011: begin
                if (w[31:25] == 7'h00 || w[31:25] == 7'h20) begin
                    if (w[14:12] == 3'd0 && w[30]) arith = ALU_SUB;
                    b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.aluop = arith; b.ctrl = C_WE;
                end else begin
                    ok = 1'b0;
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            b = '0;
            b.f3 = w[14:12];
            b.aluop = ALU_ADD;
`ifdef PANDA_ID_ILLEGAL_TRAP_EN
            b.ctrl = C_IL;
`else
            b.ctrl = C_IMM;
`endif
        end
        return b;
    endfunction

    // Starts and ends at a negedge. Optionally pulses IF give while ID is not requesting.
    task automatic run_txn(input logic [31:0] w, input int hold, input bit spur,
                           input bundle_t exp, input string tag);
        int n;
        n = 0;
        while (!get_o && n < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check({tag, ".req"}, 64'(get_o), 64'(1));
        if (!get_o) return;
        give_i = 1'b1;
        instr_i = w;
        @(posedge clk); #1;
        give_i = spur;
        instr_i = ~w;
        @(negedge clk);
        check({tag, ".decode_hs"}, 64'({get_o, give_o}), 64'(2'b00));
        @(posedge clk); #1;
        ex_get = (hold == 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, ".wait_hs"}, 64'({get_o, give_o}), 64'(2'b00));
            check({tag, ".wait_bundle"}, 64'(act), 64'(exp));
            @(posedge clk); #1;
            give_i = 1'b0;
            if (k == hold - 1) ex_get = 1'b1;
        end
        @(negedge clk);
        check({tag, ".give_hs"}, 64'({get_o, give_o}), 64'(2'b01));
        check({tag, ".give_bundle"}, 64'(act), 64'(exp));
        @(posedge clk); #1;
        ex_get = 1'b0;
        give_i = 1'b0;
        @(negedge clk);
        check({tag, ".after_hs"}, 64'({get_o, give_o}), 64'(2'b10));
        check({tag, ".after_bundle"}, 64'(act), 64'(exp));
    endtask

    vec_t        vecs [10];
    logic [6:0]  opcs [9];

    initial begin
        logic [31:0] w;
        int          sel;

        vecs[0] = '{32'h7C7FE2B7, 0, 1'b0, mk(0, 0, 5, 32'h7C7FE000, ALU_PASS_B, C_IMM | C_WE, 3'd6)};
        vecs[1] = '{32'h00118193, 5, 1'b0, mk(3, 0, 3, 32'h00000001, ALU_ADD, C_IMM | C_WE, 3'd0)};
        vecs[2] = '{32'hFC7FE2B7, 0, 1'b0, mk(0, 0, 5, 32'hFC7FE000, ALU_PASS_B, C_IMM | C_WE, 3'd6)};
        vecs[3] = '{32'hFE000EE3, 1, 1'b0, mk(0, 0, 0, 32'hFFFFFFFC, ALU_SUB, C_BR, 3'd0)};
`ifdef PANDA_ID_ILLEGAL_TRAP_EN
        vecs[4] = '{32'h0000007F, 0, 1'b0, mk(0, 0, 0, 32'h0, ALU_ADD, C_IL, 3'd0)};
`else
        vecs[4] = '{32'h0000007F, 0, 1'b0, mk(0, 0, 0, 32'h0, ALU_ADD, C_IMM, 3'd0)};
`endif
        vecs[5] = '{32'h003100B3, 2, 1'b1, mk(2, 3, 1, 32'h0, ALU_ADD, C_WE, 3'd0)};
        vecs[6] = '{32'h407302B3, 0, 1'b1, mk(6, 7, 5, 32'h0, ALU_SUB, C_WE, 3'd0)};
        vecs[7] = '{32'hFE512E23, 1, 1'b0, mk(2, 5, 0, 32'hFFFFFFFC, ALU_ADD, C_IMM | C_MW, 3'd2)};
        vecs[8] = '{32'h008000EF, 0, 1'b0, mk(0, 0, 1, 32'h00000008, ALU_ADD, C_IMM | C_PC | C_WE | C_JP, 3'd0)};
        vecs[9] = '{32'h40315093, 3, 1'b1, mk(2, 0, 1, 32'h00000403, ALU_SRA, C_IMM | C_WE, 3'd5)};
        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.hs", 64'({get_o, give_o}), 64'(2'b00));
        check("rst.bundle", 64'(act), 64'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst.release_get", 64'(get_o), 64'(1));

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].instr, vecs[i].hold, vecs[i].spur, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Randomized instructions against the model.
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            sel = $urandom_range(0, 10);
            if (sel < 9) w[6:0] = opcs[sel];
            if (w[6:0] == 7'b0110011) begin
                case ($urandom_range(0, 2))
                    0:       w[31:25] = 7'h00;
                    1:       w[31:25] = 7'h20;
                    default: w[31:25] = 7'($urandom);
                endcase
            end
            run_txn(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), model(w), $sformatf("rnd%0d", i));
        end

        // Reset while holding a bundle in PROVIDE with EX requesting.
        check("rstseq.req", 64'(get_o), 64'(1));
        give_i = 1'b1;
        instr_i = 32'h00118193;
        @(posedge clk); #1;
        give_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstseq.provide_bundle", 64'(act), 64'(model(32'h00118193)));
        @(posedge clk); #1;
        resetn = 1'b0;
        ex_get = 1'b1;
        @(negedge clk);
        check("rstseq.no_give", 64'({get_o, give_o}), 64'(2'b00));
        @(posedge clk); #1;
        resetn = 1'b1;
        ex_get = 1'b0;
        @(negedge clk);
        check("rstseq.cleared", 64'(act), 64'(0));
        check("rstseq.get_back", 64'({get_o, give_o}), 64'(2'b10));
        @(posedge clk); #1;
        @(negedge clk);
        check("rstseq.get_hold", 64'(get_o), 64'(1));

        // Normal operation after the mid-flight reset.
        run_txn(32'h7C7FE2B7, 0, 1'b0, mk(0, 0, 5, 32'h7C7FE000, ALU_PASS_B, C_IMM | C_WE, 3'd6), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction decode pipeline stage: the consumer side of the IF→ID get/give handshake and the producer side of the ID→EX handshake. It requests one 32-bit RV32I instruction from IF, captures it, and decodes register indices, the sign-extended immediate, and the ALU/control fields. It then holds the decoded bundle until EX takes it. Single-issue, one instruction in flight, no register-file read (EX/WB own the register file).

## Interface
Parameters
- BITSIZE, 32, datapath width of immediate output; only 32 supported.

Ports
- clk  in  1  clock, rising edge.
- resetn_i  in  1  reset; synchronous, active-low.
- ID_IF_get_o  out  1  request to IF; high while waiting for an instruction.
- IF_ID_give_i  in  1  IF handshake; instruction valid this cycle, honoured only while ID_IF_get_o=1.
- IF_ID_instr_i  in  32  instruction word, sampled when the give is accepted.
- EX_ID_get_i  in  1  EX request for a decoded bundle.
- ID_EX_give_o  out  1  decoded bundle valid this cycle; one-cycle pulse.
- ID_EX_rs1_o / ID_EX_rs2_o / ID_EX_rd_o  out  5 each  register indices.
- ID_EX_imm_o  out  BITSIZE  sign-extended immediate.
- ID_EX_aluop_o  out  4  alu_op_t from package.
- ID_EX_ctrl_o  out  8  ctrl_t: use_imm, use_pc, reg_we, mem_rd, mem_wr, branch, jump, illegal.
- ID_EX_funct3_o  out  3  raw funct3 (branch cond / load-store size).

## Operation
- FSM states: REQUEST, DECODE, PROVIDE.
- REQUEST: ID_IF_get_o=1. If IF_ID_give_i=1, latch IF_ID_instr_i into instr_q and go to DECODE. Otherwise stay.
- DECODE: ID_IF_get_o=0. Register all decoded outputs from instr_q, then go to PROVIDE.
- PROVIDE: outputs hold their values. If EX_ID_get_i=1, ID_EX_give_o=1 combinationally in that cycle and next state is REQUEST. Otherwise stay with give=0.
- A give on either side while the matching get is low is ignored. No data is captured and no state changes.
- Decode covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Immediate formats:
  - I: sign-extend [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All are sign-extended from bit 31 to BITSIZE.
- Unused rs1/rs2/rd fields are output as 0. Examples: LUI gives rs1=rs2=0; STORE/BRANCH give rd=0.
- OP-IMM with funct3=101 selects SRL/SRA from bit 30. OP selects ADD/SUB and SRL/SRA from bit 30.
- Unknown opcode: see Configuration.

## Timing
- Reset: state REQUEST. Every ID_EX_* output and ID_EX_give_o is 0. instr_q=0. ID_IF_get_o=0 while resetn_i=0, and 1 from the first cycle after reset deassertion.
- Latency: IF give accepted in cycle N → DECODE in N+1 → PROVIDE from N+2. Earliest ID_EX_give_o is cycle N+2.
- Throughput: at most one instruction per 3 cycles.
- ID_EX_give_o is asserted only in PROVIDE, and only when EX_ID_get_i=1. Decoded outputs are stable throughout PROVIDE and through the give cycle.
- After a give, decoded outputs keep their values until the next DECODE cycle overwrites them.
- Reset mid-operation (any state): the held instruction is discarded and no give is issued in the reset cycle. Outputs clear on the next edge.

## Configuration
- PANDA_ID_ILLEGAL_TRAP_EN defined: an unknown opcode, or a non-zero funct7 other than 0100000 on OP, sets ctrl.illegal=1. All other ctrl bits are 0, and the bundle is still provided to EX.
- PANDA_ID_ILLEGAL_TRAP_EN undefined: such instructions decode as NOP (ADDI x0,x0,0: aluop ADD, use_imm=1, reg_we=0, rd=0, imm=0), and ctrl.illegal is tied 0.

## Structure
- Shared package panda_pkg holds:
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - ctrl_t packed struct.
  - Opcode localparams: OPC_LUI=0110111, OPC_OP_IMM=0010011, etc.
- One sub-module, imm_gen: a combinational format decode plus immediate extraction. It is instantiated once, with the FSM and output registers in instr_decode.

## Test plan
- Reset, then IF gives 0x7C7FE2B7 (LUI) with EX_ID_get_i=1 → ID_EX_give_o pulses 2 cycles after acceptance with rd=5, imm=0x7C7FE000, aluop=PASS_B, reg_we=1, use_imm=1.
- IF gives 0x00118193 (ADDI x3,x3,1) with EX get held low for 5 cycles → outputs stable and give=0 and ID_IF_get_o=0 throughout. Give pulses exactly in the cycle EX get rises: rs1=3, rd=3, imm=1, aluop=ADD.
- LUI 0xFC7FE2B7 → imm=0xFC7FE000. BEQ 0xFE000EE3 → imm=0xFFFFFFFC, rd=0, branch=1.
- IF_ID_give_i pulsed while ID_IF_get_o=0 (DECODE/PROVIDE) → ignored, and the instruction from the later legitimate give is the one decoded.
- Word 0x0000007F with macro defined → illegal=1. Without the macro → NOP bundle, illegal=0.
- resetn_i low for 1 cycle during PROVIDE with EX get high → no give in the reset cycle, all outputs 0 next cycle, ID_IF_get_o=1 the cycle after.
